// File: rtl/bus_addr_latch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bus_addr_latch_decode
//  Description : 8088 bus front end. Latches the address off AD/A, decodes
//                one-hot peripheral selects and tracks each bus cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_addr_latch_decode #(
    parameter int MEM_SPLIT_BIT = 19,
    parameter int IO_SPLIT_BIT  = 15,
    parameter int TIMEOUT       = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  AD,
    input  logic [11:0] A,
    output logic [19:0] Address,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        rd_cycle,
    output logic        wr_cycle,
    output logic        timeout_err,
    output logic        proto_err,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {
        c_idle    = 2'd0,
        c_addr    = 2'd1,
        c_cmd     = 2'd2,
        c_recover = 2'd3
    } state_t;

    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [19:0] r_addr;
    logic        r_iom;
    logic [7:0]  r_wait_cnt;
    logic        r_rd_cycle;
    logic        r_wr_cycle;
    logic        r_timeout_err;
    logic        r_proto_err;
    logic [15:0] r_xfer_count;

    logic [19:0] w_dec_addr;
    logic        w_dec_iom;
    logic [3:0]  w_sel_raw;
    logic        w_sel_gate;

    // Transparent while ALE is high so selects are valid at the ALE edge itself.
    assign w_dec_addr = ALE ? {A, AD} : r_addr;
    assign w_dec_iom  = ALE ? IOM     : r_iom;

    always_comb begin
        w_sel_raw = 4'b0000;
        if (w_dec_iom)
            w_sel_raw = w_dec_addr[IO_SPLIT_BIT]  ? 4'b1000 : 4'b0100;
        else
            w_sel_raw = w_dec_addr[MEM_SPLIT_BIT] ? 4'b0010 : 4'b0001;
    end

    assign w_sel_gate = ALE || (r_state == c_addr) || (r_state == c_cmd);

    assign Address     = w_dec_addr;
    assign sel         = w_sel_gate ? w_sel_raw : 4'b0000;
    assign busy        = (r_state != c_idle);
    assign rd_cycle    = r_rd_cycle;
    assign wr_cycle    = r_wr_cycle;
    assign timeout_err = r_timeout_err;
    assign proto_err   = r_proto_err;
    assign xfer_count  = r_xfer_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= c_idle;
            r_addr        <= 20'd0;
            r_iom         <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_rd_cycle    <= 1'b0;
            r_wr_cycle    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_proto_err   <= 1'b0;
            r_xfer_count  <= 16'd0;
        end else begin
            if (ALE) begin
                r_addr <= {A, AD};
                r_iom  <= IOM;
            end
            case (r_state)
                c_idle: begin
                    if (ALE) begin
                        r_state    <= c_addr;
                        r_wait_cnt <= 8'd0;
                    end
                end
                c_addr: begin
                    if (ALE) begin
                        r_wait_cnt <= 8'd0;
                    end else if (!RD && !WR) begin
                        r_proto_err <= 1'b1;
                        r_state     <= c_idle;
                    end else if (!RD) begin
                        r_state    <= c_cmd;
                        r_rd_cycle <= 1'b1;
                        r_wr_cycle <= 1'b0;
                    end else if (!WR) begin
                        r_state    <= c_cmd;
                        r_wr_cycle <= 1'b1;
                        r_rd_cycle <= 1'b0;
                    end else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= c_idle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_cmd: begin
                    // A new ALE mid-command aborts the transfer without counting it.
                    if (ALE) begin
                        r_proto_err <= 1'b1;
                        r_state     <= c_addr;
                        r_wait_cnt  <= 8'd0;
                    end else if (RD && WR) begin
                        r_state <= c_recover;
                        if (r_xfer_count != 16'hFFFF)
                            r_xfer_count <= r_xfer_count + 16'd1;
                    end
                end
                c_recover: begin
                    if (ALE) begin
                        r_state    <= c_addr;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_addr_latch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_addr_latch_decode
//  Description : Directed self-checking bench for bus_addr_latch_decode.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_addr_latch_decode;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ALE;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic [7:0]  AD;
    logic [11:0] A;
    logic [19:0] Address;
    logic [3:0]  sel;
    logic        busy;
    logic        rd_cycle;
    logic        wr_cycle;
    logic        timeout_err;
    logic        proto_err;
    logic [15:0] xfer_count;

    int n_vec = 0;
    int n_err = 0;

    bus_addr_latch_decode #(
        .MEM_SPLIT_BIT(19),
        .IO_SPLIT_BIT (15),
        .TIMEOUT      (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALE        (ALE),
        .IOM        (IOM),
        .RD         (RD),
        .WR         (WR),
        .AD         (AD),
        .A          (A),
        .Address    (Address),
        .sel        (sel),
        .busy       (busy),
        .rd_cycle   (rd_cycle),
        .wr_cycle   (wr_cycle),
        .timeout_err(timeout_err),
        .proto_err  (proto_err),
        .xfer_count (xfer_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let outputs settle before checking.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start_cycle(input logic [11:0] a_hi, input logic [7:0] a_lo, input logic io);
        A   = a_hi;
        AD  = a_lo;
        IOM = io;
        ALE = 1'b1;
    endtask

    task automatic full_read(input logic [11:0] a_hi, input logic [7:0] a_lo);
        start_cycle(a_hi, a_lo, 1'b0);
        tick();
        ALE = 1'b0;
        RD  = 1'b0;
        tick();
        RD  = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
        AD = 8'h00; A = 12'h000;
        tick();
        tick();
        chk("rst_addr",  Address,     20'h00000);
        chk("rst_sel",   sel,         4'b0000);
        chk("rst_busy",  busy,        1'b0);
        chk("rst_rdwr",  {rd_cycle, wr_cycle}, 2'b00);
        chk("rst_errs",  {timeout_err, proto_err}, 2'b00);
        chk("rst_count", xfer_count,  16'd0);
        RESET = 1'b0;
        tick();

        // Memory read at 12345
        start_cycle(12'h123, 8'h45, 1'b0);
        settle();
        chk("mr_addr_ale", Address, 20'h12345);
        chk("mr_sel_ale",  sel,     4'b0001);
        chk("mr_busy_ale", busy,    1'b0);
        tick();
        ALE = 1'b0;
        AD  = 8'hFF;
        settle();
        chk("mr_addr_held", Address, 20'h12345);
        chk("mr_sel_addr",  sel,     4'b0001);
        chk("mr_busy_addr", busy,    1'b1);
        RD = 1'b0;
        tick();
        chk("mr_rdwr",    {rd_cycle, wr_cycle}, 2'b10);
        chk("mr_sel_cmd", sel, 4'b0001);
        tick();
        chk("mr_cnt_cmd", xfer_count, 16'd0);
        RD = 1'b1;
        tick();
        chk("mr_cnt",     xfer_count, 16'd1);
        chk("mr_sel_rec", sel, 4'b0000);
        chk("mr_busy_rec", busy, 1'b1);
        tick();
        chk("mr_idle",    busy, 1'b0);
        chk("mr_addr_end", Address, 20'h12345);

        // IO write at 08010
        start_cycle(12'h080, 8'h10, 1'b1);
        settle();
        chk("iw_sel_ale", sel, 4'b1000);
        tick();
        ALE = 1'b0;
        IOM = 1'b0;
        WR  = 1'b0;
        tick();
        chk("iw_rdwr",    {rd_cycle, wr_cycle}, 2'b01);
        chk("iw_sel_cmd", sel, 4'b1000);
        WR = 1'b1;
        tick();
        chk("iw_cnt", xfer_count, 16'd2);
        tick();

        // Strobe timeout at 80000
        start_cycle(12'h800, 8'h00, 1'b0);
        settle();
        chk("to_sel_ale", sel, 4'b0010);
        tick();
        ALE = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_err_7",  timeout_err, 1'b0);
        chk("to_busy_7", busy, 1'b1);
        chk("to_sel_7",  sel, 4'b0010);
        tick();
        chk("to_err_8",  timeout_err, 1'b1);
        chk("to_busy_8", busy, 1'b0);
        chk("to_cnt",    xfer_count, 16'd2);
        chk("to_pe",     proto_err, 1'b0);

        // Dual strobe in ADDR
        start_cycle(12'h000, 8'h10, 1'b0);
        tick();
        ALE = 1'b0;
        RD  = 1'b0;
        WR  = 1'b0;
        tick();
        RD = 1'b1;
        WR = 1'b1;
        chk("ds_pe",   proto_err, 1'b1);
        chk("ds_busy", busy, 1'b0);
        chk("ds_cnt",  xfer_count, 16'd2);
        tick();
        chk("ds_sticky", {timeout_err, proto_err}, 2'b11);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst2_errs", {timeout_err, proto_err}, 2'b00);
        chk("rst2_rdwr", {rd_cycle, wr_cycle}, 2'b00);

        // ALE during CMD
        start_cycle(12'h123, 8'h45, 1'b0);
        tick();
        ALE = 1'b0;
        RD  = 1'b0;
        tick();
        chk("ac_pe_pre", proto_err, 1'b0);
        start_cycle(12'h8F0, 8'h0F, 1'b1);
        settle();
        chk("ac_sel_ale", sel, 4'b1000);
        tick();
        ALE = 1'b0;
        RD  = 1'b1;
        AD  = 8'hAA;
        settle();
        chk("ac_pe",   proto_err, 1'b1);
        chk("ac_addr", Address, 20'h8F00F);
        chk("ac_sel",  sel, 4'b1000);
        chk("ac_busy", busy, 1'b1);
        chk("ac_cnt",  xfer_count, 16'd0);
        WR = 1'b0;
        tick();
        WR = 1'b1;
        tick();
        chk("ac_cnt_after", xfer_count, 16'd1);
        tick();

        // A few genuine transfers, then jump the counter near its ceiling
        for (int i = 0; i < 5; i++) full_read(12'h001, 8'(i));
        chk("cnt_6", xfer_count, 16'd6);
        force dut.r_xfer_count = 16'hFFFE;
        tick();
        release dut.r_xfer_count;
        full_read(12'h002, 8'h00);
        chk("sat_ffff", xfer_count, 16'hFFFF);
        full_read(12'h003, 8'h00);
        chk("sat_hold", xfer_count, 16'hFFFF);

        // Reset mid-CMD
        start_cycle(12'h0F0, 8'hF0, 1'b1);
        tick();
        ALE = 1'b0;
        WR  = 1'b0;
        tick();
        chk("mc_busy_pre", busy, 1'b1);
        chk("mc_pe_pre",   proto_err, 1'b1);
        RESET = 1'b1;
        tick();
        chk("mc_addr",  Address, 20'h00000);
        chk("mc_sel",   sel, 4'b0000);
        chk("mc_busy",  busy, 1'b0);
        chk("mc_rdwr",  {rd_cycle, wr_cycle}, 2'b00);
        chk("mc_errs",  {timeout_err, proto_err}, 2'b00);
        chk("mc_count", xfer_count, 16'd0);
        WR    = 1'b1;
        RESET = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_addr_latch_decode.md
# bus_addr_latch_decode

- Front end of the 8088 peripheral bus.
- Demultiplexes the CPU's AD[7:0]/A[19:8] lines into a stable 20-bit address, transparent while ALE is high and held afterwards, like an 8282 latch.
- Decodes the address and IOM into one-hot peripheral selects that the memory/IO peripherals sample together with ALE.
- Tracks each bus cycle with a small FSM that flags protocol errors, flags strobe timeouts and counts completed transfers.

## Interface
Parameters:
- MEM_SPLIT_BIT, 19: address bit splitting memory space into sel[0] (bit=0) and sel[1] (bit=1).
- IO_SPLIT_BIT, 15: address bit splitting IO space into sel[2] (bit=0) and sel[3] (bit=1).
- TIMEOUT, 8: cycles allowed in ADDR before a strobe must appear; legal range 2..255.

Ports:
- CLK  in  1  bus clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALE  in  1  address latch enable, active high.
- IOM  in  1  1 = IO cycle, 0 = memory cycle.
- RD  in  1  read strobe, active low.
- WR  in  1  write strobe, active low.
- AD  in  8  multiplexed low address byte; address content only while ALE=1.
- A  in  12  upper address A[19:8].
- Address  out  20  demultiplexed address.
- sel  out  4  one-hot peripheral selects.
- busy  out  1  high in ADDR, CMD and RECOVER.
- rd_cycle  out  1  current/last command was a read.
- wr_cycle  out  1  current/last command was a write.
- timeout_err  out  1  sticky; set by a strobe timeout.
- proto_err  out  1  sticky; set by a protocol violation.
- xfer_count  out  16  saturating count of completed transfers.

## Operation
Latch:
- ALE=1: Address = {A, AD} combinationally (transparent).
- Each rising edge with ALE=1 registers {A, AD} and IOM into addr_q and iom_q.
- ALE=0: Address = addr_q.

Decode:
- sel is computed from live {A, AD, IOM} while ALE=1, and from addr_q/iom_q while ALE=0.
- Memory cycles (IOM=0): sel[0] if MEM_SPLIT_BIT=0, sel[1] if it is 1.
- IO cycles (IOM=1): sel[2] if IO_SPLIT_BIT=0, sel[3] if it is 1.
- With ALE=0, sel is forced to 0 in IDLE and RECOVER.
- sel is always one-hot or zero.

FSM states: IDLE, ADDR, CMD, RECOVER.
- IDLE:
  - ALE=1 → ADDR; clear wait_cnt.
- ADDR:
  - ALE=1 → stay in ADDR, re-latch, clear wait_cnt.
  - RD=0 and WR=0 together → set proto_err → IDLE.
  - RD=0 → CMD; rd_cycle=1, wr_cycle=0.
  - WR=0 → CMD; wr_cycle=1, rd_cycle=0.
  - Otherwise wait_cnt increments. When wait_cnt reaches TIMEOUT-1 on a strobe-less cycle, set timeout_err → IDLE.
- CMD:
  - ALE=1 → set proto_err → ADDR with new latch; no count.
  - RD=1 and WR=1 → RECOVER; xfer_count+1, saturating at 16'hFFFF.
  - Otherwise stay in CMD.
- RECOVER:
  - ALE=1 → ADDR.
  - Otherwise → IDLE.
- Priority within a state: ALE, then dual-strobe error, then strobe, then timeout.
- rd_cycle and wr_cycle hold until the next command.

## Timing
- Reset (any state, including mid-cycle), next edge:
  - State goes to IDLE.
  - addr_q=0, iom_q=0, wait_cnt=0.
  - xfer_count=0, timeout_err=0, proto_err=0.
  - rd_cycle=0, wr_cycle=0, busy=0, sel=0, Address=0 (with ALE low).
- Address and sel are valid in the same cycle ALE rises, with zero latency, so a peripheral sampling ALE && sel at that edge sees the correct select.
- A normal cycle (ALE, idle, strobe low, strobe high) passes through ADDR, CMD and RECOVER. busy rises the edge after ALE is sampled.
- The xfer_count increment is visible the edge after the strobe is sampled deasserted.
- Timeout: with TIMEOUT=8, timeout_err rises on the 8th consecutive strobe-less edge in ADDR.
- Error flags are sticky; only RESET clears them.

## Test plan
- Memory read: A=12'h123, AD=8'h45, IOM=0, ALE for one cycle, RD low for 2 cycles. Expect:
  - Address=20'h12345 throughout; sel=4'b0001 during ALE through CMD.
  - rd_cycle=1; xfer_count=1; state back in IDLE 2 edges after RD rises.
- IO write: A=12'h080, AD=8'h10, IOM=1, WR low. Expect sel=4'b1000 (A15=1), wr_cycle=1, xfer_count+1.
- Timeout: ALE on 20'h80000 with no strobe, TIMEOUT=8. Expect:
  - sel=4'b0010 during the cycle.
  - timeout_err=1 after the 8th edge in ADDR; FSM returns to IDLE; xfer_count unchanged.
- Protocol errors:
  - RD and WR both low in ADDR → proto_err=1, IDLE.
  - ALE pulse during CMD → proto_err=1, re-latch to the new address, no count.
- Saturation and reset: force 65,536 transfers. Expect xfer_count=16'hFFFF, and it holds at 16'hFFFF on the next transfer. Then assert RESET mid-CMD: all outputs return to their reset values on the next edge.
